// File: rtl/macc_pkg.sv
// Shared constants and FSM state type for the nibble-serial MACC sequencer.
package macc_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } macc_seq_state_t;

endpackage : macc_pkg

// File: rtl/macc_nib_pp.sv
// Combinational WIDTH x 4 unsigned partial product shared by every nibble step.
module macc_nib_pp
  import macc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [NIB_W-1:0]       nib,
  output logic [WIDTH+NIB_W-1:0] pp
);

  localparam int unsigned PP_W = WIDTH + NIB_W;

  // Full-width product of the multiplicand and one multiplier nibble.
  assign pp = PP_W'(a) * PP_W'(nib);

endmodule : macc_nib_pp

// File: rtl/macc_nibble_seq.sv
// Nibble-serial multiplier controller: accepts (a, b), walks b one nibble per
// cycle LSB first through a shared partial-product stage, returns the product.
// Optional macro MACC_SEQ_ACC_EN: accumulator persists across transactions
// (result = previous result + a*b) and port acc_clr clears it while idle.
module macc_nibble_seq
  import macc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 2 * WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MACC_SEQ_ACC_EN
  input  logic             acc_clr,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);

  localparam int unsigned NIBS  = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned PP_W  = WIDTH + NIB_W;

  macc_seq_state_t   state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [NIB_W-1:0]  nib;
  logic [PP_W-1:0]   pp;

  // Select the multiplier nibble addressed by the step counter.
  assign nib = NIB_W'(b_q >> (NIB_W * idx_q));

  macc_nib_pp #(
    .WIDTH (WIDTH)
  ) u_pp (
    .a   (a_q),
    .nib (nib),
    .pp  (pp)
  );

  // Next-state, operand capture and accumulate logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
`ifdef MACC_SEQ_ACC_EN
        if (acc_clr) begin
          acc_d = '0;
        end
`endif
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
`ifndef MACC_SEQ_ACC_EN
          acc_d   = '0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + (ACC_W'(pp) << (NIB_W * idx_q));
        if (idx_q == IDX_W'(NIBS - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake and status decode straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = acc_q;

endmodule : macc_nibble_seq
